vga_fb_ctrl: RTL and testbench

Double-buffered frame-buffer write controller between the SPI byte receiver and the dual-bank VGA pixel RAM. Decodes the received byte stream into pixel writes and commands (align, swap, clear). Sequences back-buffer writes and a hardware clear engine. Performs tear-free bank swaps only at vertical-blank start.

---
 rtl/vga_fb_if.sv | 34 +++
 rtl/vga_fb_ctrl.sv | 175 +++++++++++++++++
 tb/tb_vga_fb_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_if.sv
// Byte-stream, frame-buffer write port and status bundle between the SPI
// receiver, the pixel RAM and the vga_fb_ctrl write controller.
interface vga_fb_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 6
) ();
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              vblank_start;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              rd_bank;
    logic [ADDR_W-1:0] addr_count;
    logic              swap_pending;
    logic              clearing;
    logic              swap_done;
    logic [15:0]       drop_count;

    // Controller side: consumes bytes/vblank, drives the RAM write port and status.
    modport master (
        input  byte_valid, byte_data, vblank_start,
        output wr_en, wr_bank, wr_addr, wr_data, rd_bank, addr_count,
               swap_pending, clearing, swap_done, drop_count
    );

    // Environment side: byte source, vblank source, RAM and status observer.
    modport slave (
        output byte_valid, byte_data, vblank_start,
        input  wr_en, wr_bank, wr_addr, wr_data, rd_bank, addr_count,
               swap_pending, clearing, swap_done, drop_count
    );
endinterface

// File: rtl/vga_fb_ctrl.sv
// Double-buffered frame-buffer write controller: decodes SPI bytes into pixel
// writes and commands, runs a clear engine and swaps banks at vblank start.
module vga_fb_ctrl #(
    parameter int RES_X = 320,
    parameter int RES_Y = 240,
    parameter int PIX_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    vga_fb_if.master   bus
);
    localparam int unsigned NPIX   = RES_X * RES_Y;
    localparam int          ADDR_W = $clog2(NPIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_CLEAR  = 1'b1
    } state_t;

    // Next pixel-stream address, wrapping at the end of the frame.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == LAST_ADDR) begin
            return ZERO_ADDR;
        end else begin
            return a + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [ADDR_W-1:0] clr_ptr_r, clr_ptr_s;
    logic              pend_r, pend_s;
    logic              rd_bank_r, rd_bank_s;
    logic              wr_bank_r, wr_bank_s;
    logic              wr_en_r, wr_en_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [PIX_W-1:0]  wr_data_r, wr_data_s;
    logic              clearing_r, clearing_s;
    logic              swap_done_r, swap_done_s;
    logic [15:0]       drop_r, drop_s;
    logic              swap_exec_s;
    logic [ADDR_W-1:0] pix_base_s;

    // Next-state and next-output decode for the stream/clear FSM.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        clr_ptr_s   = clr_ptr_r;
        pend_s      = pend_r;
        rd_bank_s   = rd_bank_r;
        wr_bank_s   = wr_bank_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        clearing_s  = clearing_r;
        drop_s      = drop_r;
        swap_exec_s = bus.vblank_start && pend_r && (state_r == ST_STREAM);
        swap_done_s = swap_exec_s;

        // A swap in the same cycle as a pixel redirects that pixel to address 0
        // of the new back bank.
        if (swap_exec_s) begin
            rd_bank_s  = ~rd_bank_r;
            wr_bank_s  = ~wr_bank_r;
            addr_s     = ZERO_ADDR;
            pend_s     = 1'b0;
            pix_base_s = ZERO_ADDR;
        end else begin
            pix_base_s = addr_r;
        end

        case (state_r)
            ST_STREAM: begin
                if (bus.byte_valid && !bus.byte_data[7]) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = pix_base_s;
                    wr_data_s = PIX_W'(bus.byte_data[5:0]);
                    addr_s    = addr_inc(pix_base_s);
                end else if (bus.byte_valid) begin
                    case (bus.byte_data)
                        8'h80: addr_s = ZERO_ADDR;
                        8'h81: begin
                            if (!pend_r) begin
                                pend_s = 1'b1;
                            end else begin
                                pend_s = pend_s;
                            end
                        end
                        8'h82: begin
                            state_s    = ST_CLEAR;
                            clearing_s = 1'b1;
                            clr_ptr_s  = ZERO_ADDR;
                        end
                        default: state_s = state_r;
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_ptr_r;
                wr_data_s = {PIX_W{1'b0}};
                if (clr_ptr_r == LAST_ADDR) begin
                    state_s    = ST_STREAM;
                    clearing_s = 1'b0;
                    addr_s     = ZERO_ADDR;
                    clr_ptr_s  = ZERO_ADDR;
                end else begin
                    clr_ptr_s  = clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
                // Only a swap request survives a clear; pixels are counted and dropped.
                if (bus.byte_valid && !bus.byte_data[7]) begin
                    if (drop_r != 16'hFFFF) begin
                        drop_s = drop_r + 16'd1;
                    end else begin
                        drop_s = drop_r;
                    end
                end else if (bus.byte_valid && (bus.byte_data == 8'h81)) begin
                    pend_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
            end
            default: begin
                state_s    = ST_STREAM;
                clearing_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_STREAM;
            addr_r      <= ZERO_ADDR;
            clr_ptr_r   <= ZERO_ADDR;
            pend_r      <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_bank_r   <= 1'b1;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= ZERO_ADDR;
            wr_data_r   <= {PIX_W{1'b0}};
            clearing_r  <= 1'b0;
            swap_done_r <= 1'b0;
            drop_r      <= 16'h0000;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            clr_ptr_r   <= clr_ptr_s;
            pend_r      <= pend_s;
            rd_bank_r   <= rd_bank_s;
            wr_bank_r   <= wr_bank_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            clearing_r  <= clearing_s;
            swap_done_r <= swap_done_s;
            drop_r      <= drop_s;
        end
    end

    assign bus.wr_en        = wr_en_r;
    assign bus.wr_bank      = wr_bank_r;
    assign bus.wr_addr      = wr_addr_r;
    assign bus.wr_data      = wr_data_r;
    assign bus.rd_bank      = rd_bank_r;
    assign bus.addr_count   = addr_r;
    assign bus.swap_pending = pend_r;
    assign bus.clearing     = clearing_r;
    assign bus.swap_done    = swap_done_r;
    assign bus.drop_count   = drop_r;
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl on a 16x8 frame (128 pixels) so full clears
// and full-frame wraps stay short.
module tb_vga_fb_ctrl;
    localparam int RES_X  = 16;
    localparam int RES_Y  = 8;
    localparam int NPIX   = RES_X * RES_Y;
    localparam int ADDR_W = $clog2(NPIX);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_fb_if #(.ADDR_W(ADDR_W), .PIX_W(6)) bus ();
    vga_fb_ctrl #(.RES_X(RES_X), .RES_Y(RES_Y), .PIX_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   n_wr;
    int   n_extra;
    logic seq_ok;
    logic done;
    logic [31:0] last_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic drive(input logic bv, input logic [7:0] bd, input logic vb);
        bus.byte_valid   = bv;
        bus.byte_data    = bd;
        bus.vblank_start = vb;
        @(negedge clk);
        bus.byte_valid   = 1'b0;
        bus.byte_data    = 8'h00;
        bus.vblank_start = 1'b0;
    endtask

    task automatic check_reset(input string pre);
        check({pre, "_wr_en"},   32'(bus.wr_en),        32'd0);
        check({pre, "_wr_bank"}, 32'(bus.wr_bank),      32'd1);
        check({pre, "_wr_addr"}, 32'(bus.wr_addr),      32'd0);
        check({pre, "_wr_data"}, 32'(bus.wr_data),      32'd0);
        check({pre, "_rd_bank"}, 32'(bus.rd_bank),      32'd0);
        check({pre, "_addr"},    32'(bus.addr_count),   32'd0);
        check({pre, "_pend"},    32'(bus.swap_pending), 32'd0);
        check({pre, "_clear"},   32'(bus.clearing),     32'd0);
        check({pre, "_done"},    32'(bus.swap_done),    32'd0);
        check({pre, "_drop"},    32'(bus.drop_count),   32'd0);
    endtask

    initial begin
        bus.byte_valid   = 1'b0;
        bus.byte_data    = 8'h00;
        bus.vblank_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;

        // Pixel stream from address 0 into bank 1.
        drive(1'b1, 8'h1B, 1'b0);
        check("p0_en", 32'(bus.wr_en), 32'd1);
        check("p0_addr", 32'(bus.wr_addr), 32'd0);
        check("p0_data", 32'(bus.wr_data), 32'h1B);
        check("p0_bank", 32'(bus.wr_bank), 32'd1);
        drive(1'b1, 8'h1B, 1'b0);
        check("p1_addr", 32'(bus.wr_addr), 32'd1);
        drive(1'b1, 8'h3F, 1'b0);
        check("p2_addr", 32'(bus.wr_addr), 32'd2);
        check("p2_data", 32'(bus.wr_data), 32'h3F);
        check("p2_cnt", 32'(bus.addr_count), 32'd3);
        drive(1'b0, 8'h00, 1'b0);
        check("idle_en", 32'(bus.wr_en), 32'd0);

        // Bit 6 ignored, then ALIGN and an unknown command.
        drive(1'b1, 8'h5B, 1'b0);
        check("b6_data", 32'(bus.wr_data), 32'h1B);
        check("b6_addr", 32'(bus.wr_addr), 32'd3);
        drive(1'b1, 8'h01, 1'b0);
        check("p4_cnt", 32'(bus.addr_count), 32'd5);
        drive(1'b1, 8'h80, 1'b0);
        check("align_cnt", 32'(bus.addr_count), 32'd0);
        check("align_en", 32'(bus.wr_en), 32'd0);
        drive(1'b1, 8'h2A, 1'b0);
        check("post_align_addr", 32'(bus.wr_addr), 32'd0);
        check("post_align_data", 32'(bus.wr_data), 32'h2A);
        drive(1'b1, 8'h9F, 1'b0);
        check("unk_en", 32'(bus.wr_en), 32'd0);
        check("unk_cnt", 32'(bus.addr_count), 32'd1);
        check("unk_pend", 32'(bus.swap_pending), 32'd0);

        // SWAP request then vblank.
        drive(1'b1, 8'h81, 1'b0);
        check("req_pend", 32'(bus.swap_pending), 32'd1);
        check("req_rd", 32'(bus.rd_bank), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        check("sw_rd", 32'(bus.rd_bank), 32'd1);
        check("sw_wr", 32'(bus.wr_bank), 32'd0);
        check("sw_cnt", 32'(bus.addr_count), 32'd0);
        check("sw_pend", 32'(bus.swap_pending), 32'd0);
        check("sw_done", 32'(bus.swap_done), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        check("sw_done_off", 32'(bus.swap_done), 32'd0);

        // Pixel coincident with an executing swap lands at address 0 of the new back bank.
        drive(1'b1, 8'h07, 1'b0);
        check("pre_bank", 32'(bus.wr_bank), 32'd0);
        drive(1'b1, 8'h81, 1'b0);
        drive(1'b1, 8'h15, 1'b1);
        check("psw_en", 32'(bus.wr_en), 32'd1);
        check("psw_addr", 32'(bus.wr_addr), 32'd0);
        check("psw_bank", 32'(bus.wr_bank), 32'd1);
        check("psw_rd", 32'(bus.rd_bank), 32'd0);
        check("psw_cnt", 32'(bus.addr_count), 32'd1);
        check("psw_done", 32'(bus.swap_done), 32'd1);

        // SWAP with vblank in the same cycle only sets pending.
        drive(1'b1, 8'h81, 1'b1);
        check("sv_pend", 32'(bus.swap_pending), 32'd1);
        check("sv_rd", 32'(bus.rd_bank), 32'd0);
        check("sv_done", 32'(bus.swap_done), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        check("sv_next_rd", 32'(bus.rd_bank), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        check("nopend_rd", 32'(bus.rd_bank), 32'd1);
        check("nopend_done", 32'(bus.swap_done), 32'd0);
        drive(1'b1, 8'h81, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check("back_rd", 32'(bus.rd_bank), 32'd0);

        // Clear with dropped pixels, a swap request, a vblank and ignored commands.
        drive(1'b1, 8'h82, 1'b0);
        check("clr_start", 32'(bus.clearing), 32'd1);
        check("clr_start_en", 32'(bus.wr_en), 32'd0);
        n_wr   = 0;
        seq_ok = 1'b1;
        done   = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            case (k)
                2, 5, 8: drive(1'b1, 8'h11, 1'b0);
                10:      drive(1'b1, 8'h81, 1'b0);
                20:      drive(1'b0, 8'h00, 1'b1);
                30:      drive(1'b1, 8'h80, 1'b0);
                31:      drive(1'b1, 8'h82, 1'b0);
                default: drive(1'b0, 8'h00, 1'b0);
            endcase
            if (bus.wr_en === 1'b1) begin
                if (bus.wr_addr !== ADDR_W'(n_wr) || bus.wr_data !== 6'd0 || bus.wr_bank !== 1'b1)
                    seq_ok = 1'b0;
                n_wr++;
            end
            if (bus.clearing !== 1'b1) done = 1'b1;
        end
        check("clr_ended", 32'(bus.clearing), 32'd0);
        check("clr_writes", 32'(n_wr), 32'(NPIX));
        check("clr_seq", 32'(seq_ok), 32'd1);
        check("clr_drop", 32'(bus.drop_count), 32'd3);
        check("clr_pend", 32'(bus.swap_pending), 32'd1);
        check("clr_rd", 32'(bus.rd_bank), 32'd0);
        check("clr_cnt", 32'(bus.addr_count), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        check("clr_idle_en", 32'(bus.wr_en), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        check("clr_sw_rd", 32'(bus.rd_bank), 32'd1);
        check("clr_sw_wr", 32'(bus.wr_bank), 32'd0);
        check("clr_sw_done", 32'(bus.swap_done), 32'd1);

        // Full frame of pixels, then wrap.
        seq_ok = 1'b1;
        last_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < NPIX; i++) begin
            drive(1'b1, 8'(i & 63), 1'b0);
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(i) || bus.wr_data !== 6'(i & 63))
                seq_ok = 1'b0;
            last_addr = 32'(bus.wr_addr);
        end
        check("frame_seq", 32'(seq_ok), 32'd1);
        check("frame_last", last_addr, 32'(NPIX - 1));
        check("frame_cnt", 32'(bus.addr_count), 32'd0);
        drive(1'b1, 8'h3C, 1'b0);
        check("wrap_addr", 32'(bus.wr_addr), 32'd0);
        check("wrap_cnt", 32'(bus.addr_count), 32'd1);
        check("wrap_bank", 32'(bus.wr_bank), 32'd0);

        // Reset in the middle of a clear with a swap pending.
        drive(1'b1, 8'h81, 1'b0);
        drive(1'b1, 8'h82, 1'b0);
        repeat (50) drive(1'b0, 8'h00, 1'b0);
        check("mid_clear", 32'(bus.clearing), 32'd1);
        check("mid_pend", 32'(bus.swap_pending), 32'd1);
        check("mid_addr", 32'(bus.wr_addr), 32'd49);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        rst = 1'b0;
        n_extra = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            if (bus.wr_en !== 1'b0) n_extra++;
        end
        check("post_rst_writes", 32'(n_extra), 32'd0);
        check("post_rst_clear", 32'(bus.clearing), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
